// File: rtl/mac_engine_if.sv
// mac_engine_if: controller-to-engine step/operand bus and result/readback signals
interface mac_engine_if #(parameter int DATA_W = 8);
  localparam int RES_W = 2 * DATA_W + 3;
  logic start_in;
  logic ALU_en;
  logic [DATA_W-1:0] a_in;
  logic [DATA_W-1:0] x_in;
  logic [1:0] rd_addr;
  logic [2:0] count_mul;
  logic ALU_done;
  logic result_valid;
  logic [1:0] result_col;
  logic [RES_W-1:0] result_data;
  logic [RES_W-1:0] rd_data;
  modport master(
    output start_in, ALU_en, a_in, x_in, rd_addr,
    input count_mul, ALU_done, result_valid, result_col, result_data, rd_data
  );
  modport slave(
    input start_in, ALU_en, a_in, x_in, rd_addr,
    output count_mul, ALU_done, result_valid, result_col, result_data, rd_data
  );
endinterface

// File: rtl/mac_engine.sv
// mac_engine: 8-step unsigned multiply-accumulate per column, 4 columns per job, buffered results
module mac_engine #(
  parameter int DATA_W = 8
) (
  input logic clk,
  input logic rst,
  mac_engine_if.slave bus
);
  localparam int RES_W = 2 * DATA_W + 3;
  typedef enum logic [1:0] {IDLE, RUN, COL_END} phase_t;
  phase_t phase, phase_nx;
  logic [RES_W-1:0] acc, prod, sum;
  logic [RES_W-1:0] mem [4];
  logic [1:0] col_cnt;
  logic step, last;
  assign bus.rd_data = mem[bus.rd_addr];
  // Outside RUN the accumulator is stale, so the first product of a column loads rather than adds
  always_comb begin
    step = bus.ALU_en && !bus.start_in;
    last = step && phase == RUN && bus.count_mul == 3'd7;
    prod = RES_W'(bus.a_in) * RES_W'(bus.x_in);
    sum = (phase == RUN ? acc : '0) + prod;
    phase_nx = bus.start_in ? IDLE : !step ? phase : !last ? RUN : col_cnt == 2'd3 ? IDLE : COL_END;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      phase <= IDLE;
      acc <= '0;
      col_cnt <= '0;
      bus.count_mul <= '0;
      bus.result_valid <= 1'b0;
      bus.ALU_done <= 1'b0;
      bus.result_col <= '0;
      bus.result_data <= '0;
      for (int i = 0; i < 4; i++) mem[i] <= '0;
    end else begin
      phase <= phase_nx;
      bus.result_valid <= last;
      bus.ALU_done <= last && col_cnt == 2'd3;
      if (bus.start_in) begin
        bus.count_mul <= '0;
        acc <= '0;
        col_cnt <= '0;
      end else if (step) begin
        bus.count_mul <= bus.count_mul + 3'd1;
        acc <= sum;
        if (last) begin
          mem[col_cnt] <= sum;
          bus.result_data <= sum;
          bus.result_col <= col_cnt;
          col_cnt <= col_cnt + 2'd1;
        end
      end
    end
  end
endmodule

// File: tb/tb_mac_engine.sv
// tb_mac_engine: randomized and directed scoreboard bench for mac_engine against a sum-of-products model
module tb_mac_engine;
  localparam int DW = 8;
  logic clk = 0;
  logic rst = 1;
  always #10 clk = ~clk;
  mac_engine_if #(.DATA_W(DW)) bus();
  mac_engine #(.DATA_W(DW)) dut(.clk(clk), .rst(rst), .bus(bus));
  typedef struct {int col; int data; bit done;} exp_t;
  exp_t q[$];
  int checks = 0;
  int passed = 0;
  int n = 0, s = 0, col = 0;
  int mem[4] = '{default: 0};
  task automatic chk(string name, longint act, longint exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask
  // Model: a column is simply the sum of its 8 enabled products
  task automatic cyc(bit en, int a, int x, bit st = 0);
    @(negedge clk);
    bus.ALU_en = en;
    bus.a_in = DW'(a);
    bus.x_in = DW'(x);
    bus.start_in = st;
    if (st) begin
      n = 0; s = 0; col = 0;
    end else if (en) begin
      s += a * x;
      n++;
      if (n == 8) begin
        q.push_back('{col, s, col == 3});
        mem[col] = s;
        col = (col + 1) % 4;
        n = 0; s = 0;
      end
    end
    @(posedge clk);
    #1;
    chk("count_mul", bus.count_mul, n);
  endtask
  task automatic check_rd();
    for (int i = 0; i < 4; i++) begin
      bus.rd_addr = 2'(i);
      #1;
      chk($sformatf("rd_data[%0d]", i), bus.rd_data, mem[i]);
    end
  endtask
  task automatic do_rst(int k);
    @(negedge clk);
    rst = 1;
    bus.ALU_en = 0;
    bus.start_in = 0;
    repeat (k) @(posedge clk);
    #1;
    rst = 0;
    n = 0; s = 0; col = 0;
    mem = '{default: 0};
    chk("rst count_mul", bus.count_mul, 0);
    chk("rst ALU_done", bus.ALU_done, 0);
    chk("rst result_valid", bus.result_valid, 0);
    chk("rst result_data", bus.result_data, 0);
    chk("rst result_col", bus.result_col, 0);
    check_rd();
  endtask
  task automatic column(int a, int x);
    for (int i = 0; i < 8; i++) cyc(1, a, x);
  endtask
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.result_valid) begin
        if (q.size() == 0) begin
          checks++;
          $display("FAIL unexpected result_valid: got col %0d data %0d expected none", bus.result_col, bus.result_data);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("result_data", bus.result_data, e.data);
          chk("result_col", bus.result_col, e.col);
          chk("ALU_done", bus.ALU_done, e.done);
        end
      end else if (bus.ALU_done) begin
        checks++;
        $display("FAIL ALU_done without result_valid: got 1 expected 0");
      end
    end
  end
  initial begin
    bus.start_in = 0; bus.ALU_en = 0; bus.a_in = 0; bus.x_in = 0; bus.rd_addr = 0;
    do_rst(2);
    for (int i = 1; i <= 8; i++) cyc(1, i, 1);
    cyc(0, 0, 0);
    do_rst(1);
    for (int c = 0; c < 4; c++) begin
      column(255, 255);
      cyc(0, 255, 255);
    end
    check_rd();
    do_rst(1);
    for (int i = 0; i < 4; i++) cyc(1, 2, 2);
    repeat (3) cyc(0, 2, 2);
    for (int i = 0; i < 4; i++) cyc(1, 2, 2);
    cyc(0, 0, 0);
    do_rst(1);
    column($urandom_range(0, 255), $urandom_range(0, 255));
    for (int i = 0; i < 5; i++) cyc(1, 7, 9);
    cyc(1, 9, 9, 1);
    column(3, 1);
    cyc(0, 0, 0);
    check_rd();
    do_rst(1);
    column(10, 10);
    column(20, 20);
    for (int i = 0; i < 6; i++) cyc(1, 5, 5);
    do_rst(1);
    column(4, 4);
    cyc(0, 0, 0);
    for (int k = 0; k < 1500; k++) begin
      int r;
      r = $urandom_range(0, 199);
      if (r == 0) do_rst(1);
      else cyc($urandom_range(0, 9) < 7, $urandom_range(0, 255), $urandom_range(0, 255), r < 4);
      if (r == 100) check_rd();
    end
    repeat (3) cyc(0, 0, 0);
    chk("scoreboard drained", q.size(), 0);
    check_rd();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/mac_engine.md
MAC_ENGINE -- requirements
Module: mac_engine

Parameters
REQ-001 DATA_W, default 8, operand width in bits; unsigned operands.
REQ-002 RES_W, fixed at 2*DATA_W+3 (19 at default), accumulator and result width; exact, never overflows for 8 products.

Interface
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start_in  input  1  new-job pulse; clears job state.
REQ-006 ALU_en  input  1  multiply-step enable from controller; one product per high cycle.
REQ-007 a_in  input  DATA_W  A-matrix operand for the current step.
REQ-008 x_in  input  DATA_W  X-matrix operand for the current step.
REQ-009 rd_addr  input  2  result buffer read index (column).
REQ-010 count_mul  output  3  product index within the current column, registered.
REQ-011 ALU_done  output  1  one-cycle pulse: all 4 columns complete.
REQ-012 result_valid  output  1  one-cycle pulse: a column result was written.
REQ-013 result_col  output  2  column index of the result flagged by result_valid.
REQ-014 result_data  output  RES_W  column result flagged by result_valid.
REQ-015 rd_data  output  RES_W  combinational read of result buffer entry rd_addr.

Function
REQ-016 Priority per cycle SHALL be rst > start_in > ALU_en > hold.
REQ-017 With ALU_en=1, count_mul SHALL increment by 1 and wrap 7->0.
REQ-018 With ALU_en=1 and count_mul=0, acc SHALL load a_in*x_in, discarding the previous value.
REQ-019 With ALU_en=1 and count_mul in 1..6, acc SHALL become acc + a_in*x_in.
REQ-020 With ALU_en=1 and count_mul=7, the sum S = acc + a_in*x_in SHALL be computed; next cycle result_data=S, result_col=col_cnt, result_valid=1; buf[col_cnt] SHALL be written with S; col_cnt increments (2-bit wrap).
REQ-021 result_valid SHALL be high for exactly one cycle per completed column; result_data/result_col hold their last values afterwards.
REQ-022 ALU_done SHALL pulse high for exactly one cycle, in the same cycle as result_valid for col_cnt=3.
REQ-023 With ALU_en=0, count_mul, acc, col_cnt and the buffer SHALL hold; this covers the controller's one-cycle next_col gap and arbitrary stalls.
REQ-024 start_in=1 SHALL clear count_mul, acc and col_cnt, and force result_valid=0 and ALU_done=0 next cycle; the buffer is retained; any simultaneous ALU_en step is discarded.
REQ-025 Latency: result visible 1 cycle after the 8th enabled step; no back-pressure.
REQ-026 rd_data SHALL reflect a buffer write in the cycle after the write edge; reading an entry being written returns the old value in the write cycle.
REQ-027 All multiply/add arithmetic SHALL be unsigned, zero-extended to RES_W before addition.
REQ-028 Internal phase state: IDLE (col_cnt=0, count_mul=0), RUN (mid-column), COL_END (count_mul wrapped, result pending); IDLE->RUN on first ALU_en; RUN->COL_END on step 7; COL_END->RUN on next ALU_en, or ->IDLE after column 3 or on start_in.

Reset
REQ-029 rst=1 SHALL set count_mul=0, acc=0, col_cnt=0, result_valid=0, ALU_done=0, result_col=0, result_data=0, and all 4 buffer entries=0.
REQ-030 rst asserted mid-column or mid-job SHALL abandon the job fully; no result_valid or ALU_done pulses follow until a new column of 8 steps completes.

Verification
REQ-031 rst high 2 cycles -> count_mul=0, ALU_done=0, result_valid=0, rd_data=0 for rd_addr 0..3.
REQ-032 8 cycles ALU_en=1, a_in=1..8, x_in=1 -> cycle after 8th step: result_valid=1, result_col=0, result_data=36; count_mul=0.
REQ-033 Full job: 4 columns of 8 steps separated by 1 idle cycle, a_in=x_in=255 -> four results each 520200, cols 0..3; ALU_done single pulse with col 3; rd_data=520200 at all addresses.
REQ-034 Stall: ALU_en low 3 cycles with count_mul=4, a_in=x_in=2 throughout -> count_mul holds 4; final result_data=32.
REQ-035 start_in pulse at count_mul=5 of column 1 -> next cycle count_mul=0, no result_valid; next 8 steps with a_in=3, x_in=1 give result_data=24 at result_col=0.
REQ-036 rst pulse at count_mul=6 of column 2 -> all outputs and buffer zero; following column of 8 steps yields result_col=0 and no ALU_done.
